// File: rtl/axis_loopback_fifo.sv
// axis_loopback_fifo: AXI4-Stream loopback buffer, MM2S sink replayed on S2MM.
//   DEPTH-entry first-word-fall-through FIFO of {tlast, tkeep, tdata}; data is
//   visible on S2MM the cycle after it is pushed. Latency: one edge.
// Backpressure: m_axis_mm2s_tready is registered and drops while the FIFO is
//   full; S2MM holds valid/data stable until s_axis_s2mm_tready.
// Ports: axi_aclk/axi_reset (async, active high); m_axis_mm2s_* stream in;
//   s_axis_s2mm_* stream out; fill_level, pkt_count, keep_err status.
// Build option AXIS_LOOPBACK_PKT_MODE_EN: store-and-forward (whole packets
//   only, with a cut-through escape for packets longer than DEPTH).
module axis_loopback_fifo #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  axi_aclk,
  input  logic                  axi_reset,
  input  logic [DATA_WIDTH-1:0] m_axis_mm2s_tdata,
  input  logic [KEEP_WIDTH-1:0] m_axis_mm2s_tkeep,
  input  logic                  m_axis_mm2s_tvalid,
  input  logic                  m_axis_mm2s_tlast,
  output logic                  m_axis_mm2s_tready,
  output logic [DATA_WIDTH-1:0] s_axis_s2mm_tdata,
  output logic [KEEP_WIDTH-1:0] s_axis_s2mm_tkeep,
  output logic                  s_axis_s2mm_tvalid,
  output logic                  s_axis_s2mm_tlast,
  input  logic                  s_axis_s2mm_tready,
  output logic [CW-1:0]         fill_level,
  output logic [CW-1:0]         pkt_count,
  output logic                  keep_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int MW = DATA_WIDTH + KEEP_WIDTH + 1;

  logic [MW-1:0]         mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         fill_q, fill_d;
  logic [CW-1:0]         pkt_q, pkt_d;
  logic                  tready_q;
  logic                  keep_err_q;
  logic                  push, pop, push_last, pop_last;
  logic                  s_vld;
  logic [MW-1:0]         rd_word;

  assign push      = m_axis_mm2s_tvalid & tready_q;
  assign pop       = s_vld & s_axis_s2mm_tready;
  assign rd_word   = mem_q[rd_ptr_q];
  assign push_last = push & m_axis_mm2s_tlast;
  assign pop_last  = pop & rd_word[MW-1];

  always_comb begin
    fill_d = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + CW'(1);
      2'b01:   fill_d = fill_q - CW'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_comb begin
    pkt_d = pkt_q;
    case ({push_last, pop_last})
      2'b10:   pkt_d = pkt_q + CW'(1);
      2'b01:   pkt_d = pkt_q - CW'(1);
      default: pkt_d = pkt_q;
    endcase
  end

  // Storage is reset so every S2MM output reads 0 while the FIFO is empty
  // after reset, and a mid-packet reset leaves no stale beat behind.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {m_axis_mm2s_tlast, m_axis_mm2s_tkeep, m_axis_mm2s_tdata};
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      pkt_q      <= '0;
      tready_q   <= 1'b0;
      keep_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      fill_q <= fill_d;
      pkt_q  <= pkt_d;
      // Looking at next-state fill keeps tready low for exactly the cycles
      // the FIFO holds DEPTH beats, so a push can never overrun it.
      tready_q <= (fill_d != CW'(DEPTH));
      if (push && !m_axis_mm2s_tlast && (m_axis_mm2s_tkeep != {KEEP_WIDTH{1'b1}}))
        keep_err_q <= 1'b1;
    end
  end

`ifdef AXIS_LOOPBACK_PKT_MODE_EN
  // NORMAL releases only whole packets. A packet that fills the FIFO without
  // a tlast can never complete in place, so OVERSIZE drains it cut-through
  // until its tlast leaves.
  typedef enum logic {NORMAL = 1'b0, OVERSIZE = 1'b1} state_e;
  state_e state_q, state_d;

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) state_q <= NORMAL;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL:   if (fill_q == CW'(DEPTH) && pkt_q == '0) state_d = OVERSIZE;
      OVERSIZE: if (pop_last) state_d = NORMAL;
      default:  state_d = NORMAL;
    endcase
  end

  always_comb begin
    s_vld = 1'b0;
    case (state_q)
      NORMAL:   s_vld = (pkt_q != '0);
      OVERSIZE: s_vld = (fill_q != '0);
      default:  s_vld = 1'b0;
    endcase
  end
`else
  assign s_vld = (fill_q != '0);
`endif

  assign m_axis_mm2s_tready = tready_q;
  assign s_axis_s2mm_tvalid = s_vld;
  assign s_axis_s2mm_tdata  = rd_word[DATA_WIDTH-1:0];
  assign s_axis_s2mm_tkeep  = rd_word[DATA_WIDTH +: KEEP_WIDTH];
  assign s_axis_s2mm_tlast  = rd_word[MW-1];
  assign fill_level         = fill_q;
  assign pkt_count          = pkt_q;
  assign keep_err           = keep_err_q;

endmodule

// File: tb/tb_axis_loopback_fifo.sv
// tb_axis_loopback_fifo: directed bench for axis_loopback_fifo (DATA_WIDTH=32,
//   DEPTH=16). Works in both builds; expectations that differ between
//   cut-through and store-and-forward are selected by AXIS_LOOPBACK_PKT_MODE_EN.
module tb_axis_loopback_fifo;

`ifdef AXIS_LOOPBACK_PKT_MODE_EN
  localparam bit SF = 1'b1;
`else
  localparam bit SF = 1'b0;
`endif

  logic        axi_aclk;
  logic        axi_reset;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid, m_tlast, m_tready;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tvalid, s_tlast, s_tready;
  logic [4:0]  fill_level, pkt_count;
  logic        keep_err;

  int n_tests = 0;
  int n_fail  = 0;

  axis_loopback_fifo dut (
    .axi_aclk           (axi_aclk),
    .axi_reset          (axi_reset),
    .m_axis_mm2s_tdata  (m_tdata),
    .m_axis_mm2s_tkeep  (m_tkeep),
    .m_axis_mm2s_tvalid (m_tvalid),
    .m_axis_mm2s_tlast  (m_tlast),
    .m_axis_mm2s_tready (m_tready),
    .s_axis_s2mm_tdata  (s_tdata),
    .s_axis_s2mm_tkeep  (s_tkeep),
    .s_axis_s2mm_tvalid (s_tvalid),
    .s_axis_s2mm_tlast  (s_tlast),
    .s_axis_s2mm_tready (s_tready),
    .fill_level         (fill_level),
    .pkt_count          (pkt_count),
    .keep_err           (keep_err)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask

  typedef struct {
    logic        mv;
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        sr;
    logic        vct;
    logic        vsf;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
    int          ef;
    int          ep;
    logic        ekerr;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  int   sent, recv, cyc, peak;
  logic exp_v;
  logic [31:0] exp_q [$];

  initial begin
    // inputs, then state observed just after the edge:
    //        mv d        k    l  sr  vct vsf ed       ek   el  fill pkt kerr
    vecs[0]  = '{1, 32'h11, 4'hF, 0, 0, 1, 0, 32'h11, 4'hF, 0, 1, 0, 0};
    vecs[1]  = '{1, 32'h22, 4'hF, 0, 0, 1, 0, 32'h11, 4'hF, 0, 2, 0, 0};
    vecs[2]  = '{1, 32'h33, 4'hF, 0, 0, 1, 0, 32'h11, 4'hF, 0, 3, 0, 0};
    vecs[3]  = '{1, 32'h44, 4'hF, 1, 0, 1, 1, 32'h11, 4'hF, 0, 4, 1, 0};
    vecs[4]  = '{0, 32'h0,  4'h0, 0, 1, 1, 1, 32'h22, 4'hF, 0, 3, 1, 0};
    vecs[5]  = '{0, 32'h0,  4'h0, 0, 1, 1, 1, 32'h33, 4'hF, 0, 2, 1, 0};
    vecs[6]  = '{0, 32'h0,  4'h0, 0, 1, 1, 1, 32'h44, 4'hF, 1, 1, 1, 0};
    vecs[7]  = '{0, 32'h0,  4'h0, 0, 1, 0, 0, 32'h0,  4'h0, 0, 0, 0, 0};
    vecs[8]  = '{1, 32'h55, 4'h7, 0, 0, 1, 0, 32'h55, 4'h7, 0, 1, 0, 1};
    vecs[9]  = '{1, 32'h66, 4'hF, 1, 0, 1, 1, 32'h55, 4'h7, 0, 2, 1, 1};
    vecs[10] = '{1, 32'h77, 4'h1, 1, 1, 1, 1, 32'h66, 4'hF, 1, 2, 2, 1};
    vecs[11] = '{1, 32'h88, 4'hF, 0, 1, 1, 1, 32'h77, 4'h1, 1, 2, 1, 1};
    vecs[12] = '{0, 32'h0,  4'h0, 0, 1, 1, 0, 32'h88, 4'hF, 0, 1, 0, 1};
    vecs[13] = '{1, 32'h99, 4'hF, 1, 0, 1, 1, 32'h88, 4'hF, 0, 2, 1, 1};
    vecs[14] = '{0, 32'h0,  4'h0, 0, 1, 1, 1, 32'h99, 4'hF, 1, 1, 1, 1};
    vecs[15] = '{0, 32'h0,  4'h0, 0, 1, 0, 0, 32'h0,  4'h0, 0, 0, 0, 1};

    // ---- reset state ----
    axi_reset = 1'b1;
    m_tvalid = 0; m_tdata = 0; m_tkeep = 0; m_tlast = 0; s_tready = 0;
    step(); step();
    chk("rst_tready", m_tready, 0);
    chk("rst_tvalid", s_tvalid, 0);
    chk("rst_tdata", s_tdata, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_kerr", keep_err, 0);
    axi_reset = 1'b0;
    #2;
    chk("rel_tready_pre", m_tready, 0);
    step();
    chk("rel_tready_post", m_tready, 1);

    // ---- table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      m_tvalid = vecs[i].mv; m_tdata = vecs[i].d; m_tkeep = vecs[i].k;
      m_tlast  = vecs[i].l;  s_tready = vecs[i].sr;
      step();
      exp_v = SF ? vecs[i].vsf : vecs[i].vct;
      chk($sformatf("vec%0d_tready", i), m_tready, 1);
      chk($sformatf("vec%0d_tvalid", i), s_tvalid, exp_v);
      chk($sformatf("vec%0d_fill", i), fill_level, vecs[i].ef);
      chk($sformatf("vec%0d_pkt", i), pkt_count, vecs[i].ep);
      chk($sformatf("vec%0d_kerr", i), keep_err, vecs[i].ekerr);
      if (exp_v) begin
        chk($sformatf("vec%0d_tdata", i), s_tdata, vecs[i].ed);
        chk($sformatf("vec%0d_tkeep", i), s_tkeep, vecs[i].ek);
        chk($sformatf("vec%0d_tlast", i), s_tlast, vecs[i].el);
      end
    end

    // ---- full: 16 beats with S2MM stalled ----
    m_tvalid = 1; m_tkeep = 4'hF; s_tready = 0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("full_tready_b%0d", i), m_tready, 1);
      m_tdata = 32'h100 + i; m_tlast = (i == 15);
      step();
    end
    chk("full_fill", fill_level, 16);
    chk("full_tready", m_tready, 0);
    m_tdata = 32'hAA; m_tlast = 1;
    step();
    chk("full_hold_fill", fill_level, 16);
    chk("full_hold_tready", m_tready, 0);
    chk("full_head", s_tdata, 32'h100);
    s_tready = 1;
    step();                               // pop only; tready was 0
    s_tready = 0;
    chk("full_pop_fill", fill_level, 15);
    chk("full_pop_tready", m_tready, 1);
    chk("full_pop_head", s_tdata, 32'h101);
    step();                               // 0xAA accepted now
    chk("refull_fill", fill_level, 16);
    chk("refull_tready", m_tready, 0);
    m_tvalid = 0; s_tready = 1;
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("drain_vld%0d", j), s_tvalid, 1);
      chk($sformatf("drain_dat%0d", j), s_tdata, (j == 15) ? 32'hAA : 32'h101 + j);
      chk($sformatf("drain_last%0d", j), s_tlast, (j >= 14) ? 1 : 0);
      step();
    end
    chk("drain_fill", fill_level, 0);
    chk("drain_vld", s_tvalid, 0);

    // ---- streaming across pointer wrap (every beat is its own packet) ----
    m_tvalid = 1; m_tlast = 1; m_tdata = 32'h200; s_tready = 0;
    step();
    s_tready = 1;
    for (int i = 1; i <= 40; i++) begin
      m_tdata = 32'h200 + i;
      chk($sformatf("wrap_dat%0d", i), s_tdata, 32'h200 + i - 1);
      step();
      chk($sformatf("wrap_fill%0d", i), fill_level, 1);
    end
    m_tvalid = 0;
    chk("wrap_tail", s_tdata, 32'h228);
    step();
    chk("wrap_empty", fill_level, 0);

    // ---- partial packet visibility ----
    m_tvalid = 1; m_tlast = 0; s_tready = 0;
    for (int i = 0; i < 3; i++) begin
      m_tdata = 32'h300 + i;
      step();
      chk($sformatf("part_vld%0d", i), s_tvalid, SF ? 0 : 1);
    end
    m_tdata = 32'h303; m_tlast = 1;
    step();
    m_tvalid = 0;
    chk("part_last_vld", s_tvalid, 1);
    chk("part_last_pkt", pkt_count, 1);
    s_tready = 1;
    for (int i = 0; i < 4; i++) step();
    chk("part_empty", fill_level, 0);

    // ---- 20-beat packet, longer than DEPTH ----
    sent = 0; recv = 0; cyc = 0; peak = 0;
    s_tready = 1;
    while (recv < 20 && cyc < 300) begin
      m_tvalid = (sent < 20);
      m_tdata  = 32'h400 + sent;
      m_tlast  = (sent == 19);
      if (s_tvalid) begin
        chk($sformatf("big_dat%0d", recv), s_tdata, 32'h400 + recv);
        chk($sformatf("big_last%0d", recv), s_tlast, (recv == 19) ? 1 : 0);
      end
      if (m_tvalid && m_tready) sent++;
      if (s_tvalid) recv++;
      step();
      if (int'(fill_level) > peak) peak = int'(fill_level);
      cyc++;
    end
    chk("big_delivered", recv, 20);
    chk("big_peak_fill", peak, SF ? 16 : 1);
    // After the oversize packet the block must be back to whole-packet mode.
    m_tvalid = 1; m_tlast = 0; m_tdata = 32'h500;
    step();
    m_tdata = 32'h501;
    step();
    m_tvalid = 0;
    chk("post_big_vld", s_tvalid, SF ? 0 : 1);
    chk("post_big_fill", fill_level, SF ? 2 : 1);

    // ---- keep error then reset mid-packet ----
    axi_reset = 1;
    #1;
    axi_reset = 0;
    s_tready = 0;
    step();
    chk("kerr_clr", keep_err, 0);
    m_tvalid = 1; m_tdata = 32'h600; m_tkeep = 4'h7; m_tlast = 0;
    step();
    chk("kerr_set", keep_err, 1);
    m_tdata = 32'h601; m_tkeep = 4'hF;
    step();
    m_tvalid = 0;
    chk("kerr_sticky", keep_err, 1);
    chk("kerr_fill", fill_level, 2);
    #2;
    axi_reset = 1;
    #1;
    chk("mid_rst_tready", m_tready, 0);
    chk("mid_rst_tvalid", s_tvalid, 0);
    chk("mid_rst_tdata", s_tdata, 0);
    chk("mid_rst_tkeep", s_tkeep, 0);
    chk("mid_rst_tlast", s_tlast, 0);
    chk("mid_rst_fill", fill_level, 0);
    chk("mid_rst_pkt", pkt_count, 0);
    chk("mid_rst_kerr", keep_err, 0);
    step();
    axi_reset = 0;
    step();
    chk("after_rst_tready", m_tready, 1);
    chk("after_rst_fill", fill_level, 0);
    chk("after_rst_vld", s_tvalid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
